victim_fill_ctrl: RTL and testbench

//  Write side of the victim cache: accepts lines evicted from the L1 data cache, buffers them in a

---
 rtl/victim_fill_if.sv | 28 ++
 rtl/victim_fill_ctrl.sv | 133 +++++++++++++
 tb/tb_victim_fill_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/victim_fill_if.sv
// Eviction handshake, invalidate request and victim-store write bus between
// the L1/retrieval side and the victim fill controller.
interface victim_fill_if #(
  parameter int WAY_BITS = 3
);
  logic                evict_valid;
  logic                evict_ready;
  logic [43:0]         evict_tag;
  logic [5:0]          evict_index;
  logic [511:0]        evict_data;
  logic                inv_en;
  logic [WAY_BITS-1:0] inv_way;
  logic                vc_wr_en;
  logic [WAY_BITS-1:0] vc_wr_way;
  logic [43:0]         vc_wr_tag;
  logic [5:0]          vc_wr_index;
  logic [511:0]        vc_wr_data;

  modport master (
    output evict_valid, evict_tag, evict_index, evict_data, inv_en, inv_way,
    input  evict_ready, vc_wr_en, vc_wr_way, vc_wr_tag, vc_wr_index, vc_wr_data
  );

  modport slave (
    input  evict_valid, evict_tag, evict_index, evict_data, inv_en, inv_way,
    output evict_ready, vc_wr_en, vc_wr_way, vc_wr_tag, vc_wr_index, vc_wr_data
  );
endinterface

// File: rtl/victim_fill_ctrl.sv
// Victim cache write side: buffers L1 evictions in a FIFO and installs each
// into a way chosen by duplicate match, then first free way, then round robin.
module victim_fill_ctrl #(
  parameter int NUM_WAYS = 8,
  parameter int WAY_BITS = 3,
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  victim_fill_if.slave        bus,
  output logic [NUM_WAYS-1:0] valid_vec,
  output logic [PTR_BITS:0]   fifo_count,
  output logic                busy
);
  localparam int KEY_W = 50;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITE} state_t;

  state_t              state_q;
  logic [43:0]         tag_mem  [DEPTH];
  logic [5:0]          idx_mem  [DEPTH];
  logic [511:0]        data_mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_BITS:0]   count_q;
  logic [KEY_W-1:0]    key_q [NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q, valid_d;
  logic [WAY_BITS-1:0] rr_q;
  logic                vc_wr_en_q;
  logic [WAY_BITS-1:0] vc_wr_way_q;
  logic [43:0]         vc_wr_tag_q;
  logic [5:0]          vc_wr_index_q;
  logic [511:0]        vc_wr_data_q;

  logic                push, pop;
  logic [KEY_W-1:0]    head_key;
  logic                hit, free;
  logic [WAY_BITS-1:0] hit_way, free_way, sel_way;

  assign bus.evict_ready = (count_q != (PTR_BITS+1)'(DEPTH));
  assign push            = bus.evict_valid && bus.evict_ready;
  assign pop             = (state_q == WRITE);
  assign head_key        = {tag_mem[rd_ptr_q], idx_mem[rd_ptr_q]};

  // Descending scan leaves the lowest-numbered match/free way selected
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    free     = 1'b0;
    free_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[w] && (key_q[w] == head_key)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[w]) begin
        free     = 1'b1;
        free_way = WAY_BITS'(w);
      end
    end
    sel_way = hit ? hit_way : (free ? free_way : rr_q);
  end

  // The install set is applied after the invalidate so a same-way write wins
  always_comb begin
    valid_d = valid_q;
    if (bus.inv_en) valid_d[bus.inv_way] = 1'b0;
    if (pop)        valid_d[vc_wr_way_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q]  <= bus.evict_tag;
      idx_mem[wr_ptr_q]  <= bus.evict_index;
      data_mem[wr_ptr_q] <= bus.evict_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      valid_q       <= '0;
      rr_q          <= '0;
      vc_wr_en_q    <= 1'b0;
      vc_wr_way_q   <= '0;
      vc_wr_tag_q   <= '0;
      vc_wr_index_q <= '0;
      vc_wr_data_q  <= '0;
      for (int w = 0; w < NUM_WAYS; w++) key_q[w] <= '0;
    end else begin
      valid_q <= valid_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_BITS+1)'(1);
        2'b01:   count_q <= count_q - (PTR_BITS+1)'(1);
        default: count_q <= count_q;
      endcase
      case (state_q)
        IDLE: begin
          if (count_q != '0) state_q <= LOOKUP;
        end
        LOOKUP: begin
          state_q       <= WRITE;
          vc_wr_en_q    <= 1'b1;
          vc_wr_way_q   <= sel_way;
          vc_wr_tag_q   <= tag_mem[rd_ptr_q];
          vc_wr_index_q <= idx_mem[rd_ptr_q];
          vc_wr_data_q  <= data_mem[rd_ptr_q];
          if (!hit && !free) rr_q <= rr_q + WAY_BITS'(1);
        end
        WRITE: begin
          state_q             <= IDLE;
          vc_wr_en_q          <= 1'b0;
          key_q[vc_wr_way_q]  <= {vc_wr_tag_q, vc_wr_index_q};
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vc_wr_en    = vc_wr_en_q;
  assign bus.vc_wr_way   = vc_wr_way_q;
  assign bus.vc_wr_tag   = vc_wr_tag_q;
  assign bus.vc_wr_index = vc_wr_index_q;
  assign bus.vc_wr_data  = vc_wr_data_q;
  assign valid_vec       = valid_q;
  assign fifo_count      = count_q;
  assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_victim_fill_ctrl.sv
// Scoreboard bench for victim_fill_ctrl: directed evictions with expected
// install ways queued at acceptance and checked by an independent monitor.
module tb_victim_fill_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] valid_vec;
  logic [2:0] fifo_count;
  logic       busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0]   way;
    logic [43:0]  tag;
    logic [5:0]   idx;
    logic [511:0] data;
  } wr_t;

  wr_t exp_q[$];

  victim_fill_if #(.WAY_BITS(3)) bus ();

  victim_fill_ctrl #(
    .NUM_WAYS(8), .WAY_BITS(3), .DEPTH(4), .PTR_BITS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .valid_vec(valid_vec),
    .fifo_count(fifo_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input int n);
    logic [511:0] r;
    for (int k = 0; k < 16; k++)
      r[k*32 +: 32] = 32'hA5A5_0000 ^ (32'(n) * 32'h0101_0101) ^ 32'(k);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.vc_wr_en) begin
      wr_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got way=%0d tag=%h idx=%h, expected no write",
                 bus.vc_wr_way, bus.vc_wr_tag, bus.vc_wr_index);
      end else begin
        e = exp_q.pop_front();
        if (bus.vc_wr_way !== e.way || bus.vc_wr_tag !== e.tag ||
            bus.vc_wr_index !== e.idx || bus.vc_wr_data !== e.data) begin
          fails++;
          $display("FAIL write: got way=%0d tag=%h idx=%h data=%h, expected way=%0d tag=%h idx=%h data=%h",
                   bus.vc_wr_way, bus.vc_wr_tag, bus.vc_wr_index, bus.vc_wr_data,
                   e.way, e.tag, e.idx, e.data);
        end
      end
    end
  end

  task automatic push(input logic [43:0] t, input logic [5:0] ix,
                      input logic [511:0] d, input logic [2:0] w);
    int g = 0;
    bus.evict_valid = 1'b1;
    bus.evict_tag   = t;
    bus.evict_index = ix;
    bus.evict_data  = d;
    while (!bus.evict_ready && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!bus.evict_ready) begin
      check("push_ready_timeout", 64'(bus.evict_ready), 64'd1);
    end else begin
      exp_q.push_back('{way: w, tag: t, idx: ix, data: d});
      @(posedge clk);
      #1;
    end
    bus.evict_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.evict_valid = 1'b0;
    bus.evict_tag   = '0;
    bus.evict_index = '0;
    bus.evict_data  = '0;
    bus.inv_en      = 1'b0;
    bus.inv_way     = '0;

    // T1: reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 64'(bus.evict_ready), 64'd1);
    check("rst_wr_en", 64'(bus.vc_wr_en), 64'd0);
    check("rst_valid_vec", 64'(valid_vec), 64'h0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_way_tag_idx", {9'd0, bus.vc_wr_way, bus.vc_wr_tag, bus.vc_wr_index}, 64'd0);
    check("rst_wr_data_zero", 64'(bus.vc_wr_data != '0), 64'd0);

    // T2: first install into empty store, two-cycle latency
    push(44'h123, 6'd5, pat(100), 3'd0);
    @(negedge clk); check("t2_lat_c1", 64'(bus.vc_wr_en), 64'd0);
    @(negedge clk); check("t2_lat_c2", 64'(bus.vc_wr_en), 64'd0);
    @(negedge clk); check("t2_lat_c3", 64'(bus.vc_wr_en), 64'd1);
    @(negedge clk); check("t2_valid_vec", 64'(valid_vec), 64'h01);
    check("t2_wr_en_low", 64'(bus.vc_wr_en), 64'd0);
    drain("t2_drain");

    // T3: fill ways 0..7 in order, then round robin 0, 1
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) push(44'h123, 6'd5, pat(3), 3'd3);
      else        push(44'hA00 + 44'(i), 6'(i), pat(i), 3'(i));
    end
    push(44'hB08, 6'd8, pat(8), 3'd0);
    push(44'hB09, 6'd9, pat(9), 3'd1);
    drain("t3_drain");
    check("t3_valid_vec", 64'(valid_vec), 64'hFF);

    // T4: duplicate key replaces its own way
    push(44'h123, 6'd5, pat(200), 3'd3);
    drain("t4_drain");

    // T5: six back-to-back misses; round robin continues from 2
    for (int i = 0; i < 5; i++) push(44'hC00 + 44'(i), 6'(16 + i), pat(300 + i), 3'(2 + i));
    check("t5_count_full", 64'(fifo_count), 64'd4);
    check("t5_ready_low", 64'(bus.evict_ready), 64'd0);
    push(44'hC05, 6'd21, pat(305), 3'd7);
    drain("t5_drain");

    // T6: invalidate then refill into the freed way
    @(negedge clk);
    bus.inv_en  = 1'b1;
    bus.inv_way = 3'd2;
    @(posedge clk);
    #1;
    bus.inv_en = 1'b0;
    check("t6_inv_valid_vec", 64'(valid_vec), 64'hFB);
    push(44'hD00, 6'd1, pat(400), 3'd2);
    drain("t6_free_drain");
    check("t6_refill_valid_vec", 64'(valid_vec), 64'hFF);

    // Same-edge invalidate and write to way 5 (key now held there is C03/19)
    push(44'hC03, 6'd19, pat(401), 3'd5);
    begin
      int g = 0;
      while (!bus.vc_wr_en && g < 50) begin
        @(negedge clk);
        g++;
      end
    end
    check("t6_wr_seen", 64'(bus.vc_wr_en), 64'd1);
    bus.inv_en  = 1'b1;
    bus.inv_way = 3'd5;
    @(posedge clk);
    #1;
    bus.inv_en = 1'b0;
    check("t6_write_wins", 64'(valid_vec[5]), 64'd1);
    drain("t6_dup_drain");

    // Round robin pointer untouched by free/duplicate selections: still 0
    push(44'hD01, 6'd2, pat(402), 3'd0);
    drain("t6_rr_drain");

    // Reset during LOOKUP drops the pending write
    push(44'hD02, 6'd3, pat(403), 3'd1);
    @(posedge clk);
    #1;
    check("t6_busy_lookup", 64'(busy), 64'd1);
    void'(exp_q.pop_back());
    pulse_reset();
    check("t6_rst_fifo_count", 64'(fifo_count), 64'd0);
    check("t6_rst_valid_vec", 64'(valid_vec), 64'h0);
    check("t6_rst_wr_en", 64'(bus.vc_wr_en), 64'd0);
    repeat (6) @(negedge clk);
    check("t6_rst_idle", 64'(busy), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
